alu3_sequencer: RTL and testbench

ALU3_SEQUENCER -- requirements
Module: alu3_sequencer

---
 rtl/alu3_sequencer_if.sv | 11 +
 rtl/alu3_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu3_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu3_sequencer_if.sv
// alu3_sequencer_if: switch/LED/seven-segment bundle for the three-step ALU sequencer.
// The board side (bench or top-level pad ring) uses the master modport;
// the sequencer core uses the slave modport.
interface alu3_sequencer_if;
   logic [7:0] SWI;
   logic [7:0] LED;
   logic [7:0] SEG;

   modport master (output SWI, input LED, input SEG);
   modport slave  (input SWI, output LED, output SEG);
endinterface

// File: rtl/alu3_sequencer.sv
// alu3_sequencer: step-switch driven 3-bit signed ALU.
// The operator captures A, then B and the opcode, with one step press each.
// The block then computes for one cycle and shows the result for HOLD_CYCLES cycles.
// Optional feature: define ALU3_SEQ_OPCOUNT_EN to show a 2-bit operation
// counter on LED[7:6]. Without it, those LEDs read 00.
module alu3_sequencer #(
   parameter int HOLD_CYCLES = 8
) (
   input logic           clk_2,
   input logic           reset,
   alu3_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAIT_B = 2'b01,
      EXEC   = 2'b10,
      SHOW   = 2'b11
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   // Step-switch synchroniser, edge detector and post-reset arming
   logic       sync1_q;
   logic       sync2_q;
   logic       prev_q;
   logic [1:0] fill_q;
   logic       armed_q;
   logic       stepPulse;

   // Sequencer state and datapath registers
   state_t     state_q;
   logic [2:0] opA_q;
   logic [2:0] opB_q;
   logic [1:0] opSel_q;
   logic [2:0] result_q;
   logic       ovf_q;
   logic [7:0] seg_q;
   logic [7:0] holdCnt_q;
   logic [1:0] ledTop;

   // Next values for the result registers, loaded only in EXEC
   logic [2:0] result_d;
   logic       ovf_d;
   logic [7:0] seg_d;
   logic [2:0] sum;
   logic [2:0] diff;

   // Bits SWI[2:1] have no function
   logic       unusedSwi;
   assign unusedSwi = ^bus.SWI[2:1];

`ifdef ALU3_SEQ_OPCOUNT_EN
   logic [1:0] opCount_q;
   assign ledTop = opCount_q;
`else
   assign ledTop = 2'b00;
`endif

   // Seven-segment code for a 3-bit signed value, or the overflow code
   function automatic logic [7:0] segCode(input logic [2:0] value, input logic ovf);
      logic [7:0] code;
      if (ovf) begin
         code = 8'hBF;
      end else begin
         case (value)
            3'b100:  code = 8'hE6;
            3'b101:  code = 8'hCF;
            3'b110:  code = 8'hDB;
            3'b111:  code = 8'h86;
            3'b000:  code = 8'h3F;
            3'b001:  code = 8'h06;
            3'b010:  code = 8'h5B;
            default: code = 8'h4F;
         endcase
      end
      return code;
   endfunction

   // A step is a rising edge of the synchronised switch.
   // No step can fire until the switch has been seen low after reset.
   assign stepPulse = armed_q & sync2_q & ~prev_q;

   // Two-flop synchroniser, edge history and arming.
   // fill_q waits two cycles for the synchroniser to fill, so cleared reset
   // values are never taken as a genuine "switch low" observation.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         fill_q  <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= bus.SWI[0];
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         fill_q  <= {fill_q[0], 1'b1};
         armed_q <= armed_q | (fill_q[1] & ~sync2_q);
      end
   end

   // ALU on the captured operands.
   // Overflow for add/subtract is signed overflow on the effective B sign.
   always_comb begin
      result_d = 3'b000;
      ovf_d    = 1'b0;
      sum      = opA_q + opB_q;
      diff     = opA_q - opB_q;
      case (opSel_q)
         2'b00: begin
            result_d = sum;
            ovf_d    = (opA_q[2] == opB_q[2]) && (sum[2] != opA_q[2]);
         end
         2'b01: begin
            result_d = diff;
            ovf_d    = (opA_q[2] == ~opB_q[2]) && (diff[2] != opA_q[2]);
         end
         2'b10:   result_d = opA_q & opB_q;
         default: result_d = opA_q | opB_q;
      endcase
      seg_d = segCode(result_d, ovf_d);
   end

   // Sequencer FSM. Result, overflow and SEG are all registered and change only in EXEC.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         opA_q     <= 3'b000;
         opB_q     <= 3'b000;
         opSel_q   <= 2'b00;
         result_q  <= 3'b000;
         ovf_q     <= 1'b0;
         seg_q     <= 8'h3F;
         holdCnt_q <= 8'd0;
`ifdef ALU3_SEQ_OPCOUNT_EN
         opCount_q <= 2'b00;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (stepPulse) begin
                  opA_q   <= bus.SWI[7:5];
                  state_q <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (stepPulse) begin
                  opB_q   <= bus.SWI[7:5];
                  opSel_q <= bus.SWI[4:3];
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q  <= result_d;
               ovf_q     <= ovf_d;
               seg_q     <= seg_d;
               holdCnt_q <= 8'd0;
               state_q   <= SHOW;
`ifdef ALU3_SEQ_OPCOUNT_EN
               opCount_q <= opCount_q + 2'b01;
`endif
            end
            SHOW: begin
               if (stepPulse) begin
                  opA_q   <= bus.SWI[7:5];
                  state_q <= WAIT_B;
               end else if (holdCnt_q == HOLD_LAST) begin
                  state_q <= IDLE;
               end else begin
                  holdCnt_q <= holdCnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.LED = {ledTop, state_q, ovf_q, result_q};
   assign bus.SEG = seg_q;

endmodule

// File: tb/tb_alu3_sequencer.sv
// tb_alu3_sequencer: directed self-checking bench for alu3_sequencer.
// The expected values are hand-computed from the operand/opcode vectors.
module tb_alu3_sequencer;

   logic clk_2 = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   opsDone = 0;
   logic [1:0] st;

   alu3_sequencer_if bus();

   alu3_sequencer #(.HOLD_CYCLES(8)) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

   // 10 time-unit clock
   always #5 clk_2 = ~clk_2;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Expected LED[7:6] given the number of EXECs since the last reset
   function automatic logic [1:0] expCount();
`ifdef ALU3_SEQ_OPCOUNT_EN
      return 2'(opsDone);
`else
      return 2'b00;
`endif
   endfunction

   // Press the step switch with a value on SWI[7:3].
   // Returns LED[5:4] three cycles after the press, when the step has just been consumed.
   // Then releases the switch long enough for the next press to register.
   task automatic applyStimulus(input logic [2:0] val, input logic [1:0] op, output logic [1:0] stateAt3);
      bus.SWI = {val, op, 3'b001};
      repeat (3) @(negedge clk_2);
      stateAt3 = bus.LED[5:4];
      @(negedge clk_2);
      bus.SWI[0] = 1'b0;
      repeat (2) @(negedge clk_2);
   endtask

   // Called in SHOW cycle 3: check the result, the SHOW length and the hold in IDLE
   task automatic finishOp(input logic [2:0] expRes, input logic expOvf, input logic [7:0] expSeg);
      int showCycles;
      opsDone++;
      checkOutput("showState", bus.LED[5:4], 2'b11);
      checkOutput("result", bus.LED[2:0], expRes);
      checkOutput("overflow", bus.LED[3], expOvf);
      checkOutput("seg", bus.SEG, expSeg);
      checkOutput("opCount", bus.LED[7:6], expCount());
      showCycles = 3;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_2);
         if (bus.LED[5:4] != 2'b11) break;
         showCycles++;
      end
      checkOutput("showLength", showCycles, 8);
      checkOutput("idleState", bus.LED[5:4], 2'b00);
      checkOutput("idleResult", bus.LED[2:0], expRes);
      checkOutput("idleSeg", bus.SEG, expSeg);
   endtask

   // Full operation: A step, then B/op step, then result checks
   task automatic doOp(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                       input logic [2:0] expRes, input logic expOvf, input logic [7:0] expSeg);
      logic [1:0] s;
      applyStimulus(a, 2'b00, s);
      checkOutput("captureA", s, 2'b01);
      applyStimulus(b, op, s);
      checkOutput("execState", s, 2'b10);
      finishOp(expRes, expOvf, expSeg);
   endtask

   initial begin
      bus.SWI = 8'h00;
      reset   = 1'b1;
      repeat (2) @(negedge clk_2);
      checkOutput("resetLed", bus.LED, 8'h00);
      checkOutput("resetSeg", bus.SEG, 8'h3F);
      reset = 1'b0;
      repeat (4) @(negedge clk_2);
      checkOutput("idleAfterReset", bus.LED, 8'h00);

      // Arithmetic and logic vectors
      doOp(3'b011, 3'b001, 2'b00, 3'b100, 1'b1, 8'hBF);
      doOp(3'b010, 3'b011, 2'b01, 3'b111, 1'b0, 8'h86);
      doOp(3'b100, 3'b001, 2'b01, 3'b011, 1'b1, 8'hBF);
      doOp(3'b110, 3'b011, 2'b10, 3'b010, 1'b0, 8'h5B);
      doOp(3'b110, 3'b011, 2'b11, 3'b111, 1'b0, 8'h86);

      // Abort SHOW with a step in SHOW cycle 3; the new A must be captured
      applyStimulus(3'b001, 2'b00, st);
      checkOutput("abortCaptureA", st, 2'b01);
      bus.SWI = {3'b001, 2'b00, 3'b001};
      repeat (3) @(negedge clk_2);
      checkOutput("abortExec", bus.LED[5:4], 2'b10);
      bus.SWI[0] = 1'b0;
      @(negedge clk_2);
      opsDone++;
      checkOutput("abortShow1", bus.LED[5:4], 2'b11);
      checkOutput("abortResult", bus.LED[2:0], 3'b010);
      checkOutput("abortSeg", bus.SEG, 8'h5B);
      bus.SWI = {3'b101, 2'b00, 3'b001};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_2);
         checkOutput("abortShowHold", bus.LED[5:4], 2'b11);
      end
      @(negedge clk_2);
      checkOutput("abortWaitB", bus.LED[5:4], 2'b01);
      bus.SWI[0] = 1'b0;
      repeat (2) @(negedge clk_2);
      applyStimulus(3'b001, 2'b00, st);
      checkOutput("abortExec2", st, 2'b10);
      finishOp(3'b110, 1'b0, 8'hDB);

      // WAIT_B waits indefinitely, then reset with the step switch held high
      applyStimulus(3'b010, 2'b00, st);
      checkOutput("rstCaptureA", st, 2'b01);
      repeat (20) @(negedge clk_2);
      checkOutput("waitBHolds", bus.LED[5:4], 2'b01);
      bus.SWI[0] = 1'b1;
      @(negedge clk_2);
      reset = 1'b1;
      #1;
      checkOutput("midResetLed", bus.LED, 8'h00);
      checkOutput("midResetSeg", bus.SEG, 8'h3F);
      @(negedge clk_2);
      reset   = 1'b0;
      opsDone = 0;
      repeat (10) @(negedge clk_2);
      checkOutput("noPulseLed", bus.LED, 8'h00);
      checkOutput("noPulseSeg", bus.SEG, 8'h3F);
      bus.SWI[0] = 1'b0;
      repeat (3) @(negedge clk_2);
      checkOutput("stillIdle", bus.LED[5:4], 2'b00);
      doOp(3'b011, 3'b011, 2'b10, 3'b011, 1'b0, 8'h4F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
